caravel_mem_bus: RTL and testbench

External memory bus unit of the Caravel user-project RISC-V core. It converts 32-bit CPU load/store requests into transfers on a 16-bit multiplexed address/data pad bus. The bus drives two external transparent address latches (low and high 16 bits), output-enable, and per-byte write strobes. It sits between the core's load/store/fetch arbiter and the `mprj_io` pads.

---
 rtl/caravel_mem_bus.sv | 104 ++++++++++
 tb/tb_caravel_mem_bus.sv | 127 ++++++++++++
 2 files changed

// File: rtl/caravel_mem_bus.sv
// caravel_mem_bus: 32-bit load/store to 16-bit multiplexed address/data pad bus bridge
module caravel_mem_bus (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  wmask,
  output logic [31:0] rdata,
  output logic        ack,
  input  logic [15:0] bus_in,
  output logic [15:0] bus_out,
  output logic        bus_oe,
  output logic        le_lo,
  output logic        le_hi,
  output logic        bus_dir,
  output logic        OEb,
  output logic        WEb_lo,
  output logic        WEb_hi
);
  typedef enum logic [3:0] {IDLE, AHI, ALO, RD_OE, RD_SMP, WR_DAT, WR_STB, WR_HLD, DONE} state_t;
  state_t state, nxt;
  logic h, h_n, we_r, we_n, last, unused;
  logic [29:0] a_r, a_n;
  logic [31:0] wd_r, wd_n, ea;
  logic [3:0] wm_r, wm_n;
  logic [15:0] bus_out_n;
  logic wr_n, bus_oe_n, bus_dir_n, web_lo_n, web_hi_n;
  assign unused = ^addr[1:0];
  always_comb begin
    nxt = state;
    h_n = h;
    last = h || (we_r && wm_r[3:2] == 2'b00);
    case (state)
      IDLE: if (req) begin
        nxt = (we && wmask == 4'b0000) ? DONE : AHI;
        h_n = we && wmask[1:0] == 2'b00;
      end
      AHI: nxt = ALO;
      ALO: nxt = we_r ? WR_DAT : RD_OE;
      RD_OE: nxt = RD_SMP;
      WR_DAT: nxt = WR_STB;
      WR_STB: nxt = WR_HLD;
      RD_SMP, WR_HLD: begin
        nxt = last ? DONE : AHI;
        h_n = 1'b1;
      end
      DONE: nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end
  always_comb begin
    a_n = (state == IDLE && req) ? addr[31:2] : a_r;
    wd_n = (state == IDLE && req) ? wdata : wd_r;
    wm_n = (state == IDLE && req) ? wmask : wm_r;
    we_n = (state == IDLE && req) ? we : we_r;
    ea = {1'b0, a_n, h_n};
    wr_n = nxt == WR_DAT || nxt == WR_STB || nxt == WR_HLD;
    bus_out_n = nxt == AHI ? ea[31:16] : nxt == ALO ? ea[15:0] : wr_n ? (h_n ? wd_n[31:16] : wd_n[15:0]) : 16'h0000;
    bus_oe_n = nxt == AHI || nxt == ALO || wr_n;
    bus_dir_n = nxt == RD_OE || nxt == RD_SMP;
    web_lo_n = !(nxt == WR_STB && wm_n[{h_n, 1'b0}]);
    web_hi_n = !(nxt == WR_STB && wm_n[{h_n, 1'b1}]);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      h <= 1'b0;
      we_r <= 1'b0;
      a_r <= '0;
      wd_r <= '0;
      wm_r <= '0;
      rdata <= '0;
      ack <= 1'b0;
      bus_out <= '0;
      bus_oe <= 1'b0;
      le_lo <= 1'b0;
      le_hi <= 1'b0;
      bus_dir <= 1'b0;
      OEb <= 1'b1;
      WEb_lo <= 1'b1;
      WEb_hi <= 1'b1;
    end else begin
      state <= nxt;
      h <= h_n;
      we_r <= we_n;
      a_r <= a_n;
      wd_r <= wd_n;
      wm_r <= wm_n;
      if (state == RD_SMP && h) rdata[31:16] <= bus_in;
      if (state == RD_SMP && !h) rdata[15:0] <= bus_in;
      ack <= nxt == DONE;
      bus_out <= bus_out_n;
      bus_oe <= bus_oe_n;
      le_lo <= nxt == ALO;
      le_hi <= nxt == AHI;
      bus_dir <= bus_dir_n;
      OEb <= !bus_dir_n;
      WEb_lo <= web_lo_n;
      WEb_hi <= web_hi_n;
    end
  end
endmodule

// File: tb/tb_caravel_mem_bus.sv
// tb_caravel_mem_bus: directed checks of caravel_mem_bus against a latch/memory pad model
module tb_caravel_mem_bus;
  logic clk = 1'b0, rst_n = 1'b0, req = 1'b0, we = 1'b0;
  logic [31:0] addr = '0, wdata = '0, rdata;
  logic [3:0] wmask = '0;
  logic ack, bus_oe, le_lo, le_hi, bus_dir, OEb, WEb_lo, WEb_hi;
  logic [15:0] bus_in, bus_out;
  logic [15:0] mem [0:511];
  logic [15:0] a_hi = '0, a_lo = '0, stb_d = '0;
  logic [31:0] lat [0:3];
  logic [31:0] rd = '0;
  int n_lat = 0, stb_lo = 0, stb_hi = 0, viol = 0, ack_cyc = 0, errors = 0, checks = 0;
  caravel_mem_bus dut (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we), .addr(addr), .wdata(wdata), .wmask(wmask),
    .rdata(rdata), .ack(ack), .bus_in(bus_in), .bus_out(bus_out), .bus_oe(bus_oe),
    .le_lo(le_lo), .le_hi(le_hi), .bus_dir(bus_dir), .OEb(OEb), .WEb_lo(WEb_lo), .WEb_hi(WEb_hi)
  );
  always #5 clk = ~clk;
  assign bus_in = OEb ? 16'h0000 : mem[a_lo[8:0]];
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(negedge clk);
    if (bus_oe && bus_dir) viol++;
    if (!OEb && (!WEb_lo || !WEb_hi)) viol++;
    if (le_hi) a_hi = bus_out;
    if (le_lo) begin
      a_lo = bus_out;
      if (n_lat < 4) lat[n_lat] = {a_hi, bus_out};
      n_lat++;
    end
    if (!WEb_lo) begin
      mem[a_lo[8:0]][7:0] = bus_out[7:0];
      stb_lo++;
      stb_d = bus_out;
    end
    if (!WEb_hi) begin
      mem[a_lo[8:0]][15:8] = bus_out[15:8];
      stb_hi++;
      stb_d = bus_out;
    end
  endtask
  task automatic run(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
    req = 1'b1; we = w; addr = a; wdata = d; wmask = m;
    ack_cyc = 0; n_lat = 0; stb_lo = 0; stb_hi = 0;
    for (int c = 1; c <= 30 && ack_cyc == 0; c++) begin
      step();
      if (ack) begin
        ack_cyc = c;
        rd = rdata;
      end
    end
    req = 1'b0;
    step();
  endtask
  initial begin
    for (int i = 0; i < 512; i++) mem[i] = 16'h0000;
    mem[0] = 16'h0013;
    for (int i = 0; i < 4; i++) lat[i] = '0;
    repeat (3) step();
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_ack", {31'b0, ack}, 32'h0);
    chk("rst_bus_out", {16'h0, bus_out}, 32'h0);
    chk("rst_ctl", {25'b0, bus_oe, le_lo, le_hi, bus_dir, OEb, WEb_lo, WEb_hi}, 32'h07);
    rst_n = 1'b1;
    step();
    run(1'b0, 32'h0000_0000, 32'h0, 4'hF);
    chk("ld0_ack_cyc", ack_cyc, 9);
    chk("ld0_rdata", rd, 32'h0000_0013);
    chk("ld0_nlat", n_lat, 2);
    chk("ld0_lat0", lat[0], 32'h0000_0000);
    chk("ld0_lat1", lat[1], 32'h0000_0001);
    run(1'b1, 32'h0040_000C, 32'h0000_0041, 4'b0001);
    chk("st1_ack_cyc", ack_cyc, 6);
    chk("st1_nlat", n_lat, 1);
    chk("st1_lat0", lat[0], 32'h0020_0006);
    chk("st1_stb_lo", stb_lo, 1);
    chk("st1_stb_hi", stb_hi, 0);
    chk("st1_data", {24'h0, stb_d[7:0]}, 32'h41);
    chk("st1_mem", {24'h0, mem[9'h006][7:0]}, 32'h41);
    run(1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 4'b1111);
    chk("st4_ack_cyc", ack_cyc, 11);
    chk("st4_stb_lo", stb_lo, 2);
    chk("st4_stb_hi", stb_hi, 2);
    chk("st4_lat0", lat[0], 32'h0000_0080);
    chk("st4_lat1", lat[1], 32'h0000_0081);
    chk("st4_mem0", {16'h0, mem[9'h080]}, 32'hBEEF);
    chk("st4_mem1", {16'h0, mem[9'h081]}, 32'hDEAD);
    run(1'b0, 32'h0000_0100, 32'h0, 4'h0);
    chk("ld4_ack_cyc", ack_cyc, 9);
    chk("ld4_rdata", rd, 32'hDEAD_BEEF);
    run(1'b1, 32'h0000_0100, 32'h1234_5678, 4'b0000);
    chk("st0_ack_cyc", ack_cyc, 1);
    chk("st0_nlat", n_lat, 0);
    chk("st0_stb", stb_lo + stb_hi, 0);
    run(1'b1, 32'h0000_0100, 32'h1234_0000, 4'b1100);
    chk("sthi_ack_cyc", ack_cyc, 6);
    chk("sthi_lat0", lat[0], 32'h0000_0081);
    chk("sthi_stb", {stb_hi[15:0], stb_lo[15:0]}, 32'h0001_0001);
    chk("sthi_mem1", {16'h0, mem[9'h081]}, 32'h1234);
    chk("sthi_mem0", {16'h0, mem[9'h080]}, 32'hBEEF);
    req = 1'b1; we = 1'b0; addr = 32'h0000_0100;
    repeat (4) step();
    chk("mid_oeb", {31'b0, OEb}, 32'h0);
    rst_n = 1'b0; req = 1'b0;
    step();
    chk("mid_ack", {31'b0, ack}, 32'h0);
    chk("mid_rdata", rdata, 32'h0);
    chk("mid_bus_out", {16'h0, bus_out}, 32'h0);
    chk("mid_ctl", {25'b0, bus_oe, le_lo, le_hi, bus_dir, OEb, WEb_lo, WEb_hi}, 32'h07);
    step();
    chk("mid_ack2", {31'b0, ack}, 32'h0);
    rst_n = 1'b1;
    step();
    run(1'b0, 32'h0000_0000, 32'h0, 4'h0);
    chk("post_ack_cyc", ack_cyc, 9);
    chk("post_rdata", rd, 32'h0000_0013);
    chk("contention", viol, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
